// File: rtl/fma_pkg.sv
// Shared definitions for the FMA addend pipeline.
//   FMA_PW / FMA_AW / FMA_TW : default partial-product, sum and tag widths.
//   sel_mode_e               : how the final magnitude is chosen from the
//                              carry-propagate results.
package fma_pkg;

    localparam int FMA_PW = 106;
    localparam int FMA_AW = 158;
    localparam int FMA_TW = 4;

    // ADD0 : plain add, magnitude is sum0
    // ADD1 : subtract with non-negative result, magnitude is sum0 + 1
    // INV0 : subtract with negative result, magnitude is ~sum0
    typedef enum logic [1:0] {
        ADD0 = 2'd0,
        ADD1 = 2'd1,
        INV0 = 2'd2
    } sel_mode_e;

endpackage

// File: rtl/fma_add_pipe_if.sv
// Operand / result channel bundle for fma_add_pipe.
//   Input channel : in_valid, in_ready, r, s, t, invz, killprod, tag_in
//   Output channel: out_valid, out_ready, mag, negsum, zero, tag_out
//   Control       : flush
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds its payload stable while valid=1 and ready=0;
// ready may depend combinationally on the downstream ready.
// modport master : the side that supplies operands and consumes results.
// modport slave  : the pipeline.
interface fma_add_pipe_if
    import fma_pkg::*;
#(
    parameter int PW = FMA_PW,
    parameter int AW = FMA_AW,
    parameter int TW = FMA_TW
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] r;
    logic [PW-1:0] s;
    logic [AW-1:0] t;
    logic          invz;
    logic          killprod;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] mag;
    logic          negsum;
    logic          zero;
    logic [TW-1:0] tag_out;

    modport master (
        output in_valid, r, s, t, invz, killprod, tag_in, flush, out_ready,
        input  in_ready, out_valid, mag, negsum, zero, tag_out
    );

    modport slave (
        input  in_valid, r, s, t, invz, killprod, tag_in, flush, out_ready,
        output in_ready, out_valid, mag, negsum, zero, tag_out
    );
endinterface

// File: rtl/fma_csa32.sv
// 3:2 carry-save adder, purely combinational.
//   a, b, c : W-bit addends
//   sum     : bitwise sum vector
//   carry   : majority vector shifted left by one, truncated to W bits
// sum + carry == a + b + c (mod 2^W).
module fma_csa32 #(
    parameter int W = 158
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    always_comb begin
        sum   = a ^ b ^ c;
        maj   = (a & b) | (a & c) | (b & c);
        carry = {maj[W-2:0], 1'b0};
    end
endmodule

// File: rtl/fma_add_pipe.sv
// Two-stage addend/product adder for a fused multiply-add datapath.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fma_add_pipe_if.slave (operands in, magnitude/sign/zero out)
// Stage 1 reduces {r, s, t} to carry-save form; stage 2 resolves the carry
// chain and picks the magnitude and sign of the signed sum.
module fma_add_pipe
    import fma_pkg::*;
#(
    parameter int PW = FMA_PW,
    parameter int AW = FMA_AW,
    parameter int TW = FMA_TW
) (
    input  logic clk,
    input  logic reset,
    fma_add_pipe_if.slave bus
);
    // Stall control: a stage may advance if it is empty or the stage after it
    // advances, so a full pipeline moves in lock-step with out_ready.
    logic adv1;
    logic adv2;

    // Stage 1 state
    logic          v1_q, v1_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [AW-1:0] carry_q, carry_d;
    logic          invz1_q, invz1_d;
    logic [TW-1:0] tag1_q, tag1_d;

    // Stage 2 state
    logic          v2_q, v2_d;
    logic [AW-1:0] mag_q, mag_d;
    logic          negsum_q, negsum_d;
    logic          zero_q, zero_d;
    logic [TW-1:0] tag2_q, tag2_d;

    // Operand conditioning and CSA
    logic [AW-1:0] r2, s2, t2;
    logic [AW-1:0] csa_sum, csa_carry;

    // Stage 2 datapath
    logic [AW-1:0] sum0, sum1;
    sel_mode_e     sel_mode;
    logic [AW-1:0] sel_mag;
    logic          sel_neg;

    always_comb begin
        adv2 = !v2_q || bus.out_ready;
        adv1 = !v1_q || adv2;
    end

    // Subtraction uses ~t; the missing +1 of the two's complement is added
    // back in stage 2 as sum1 = sum0 + 1.
    always_comb begin
        r2 = bus.killprod ? '0 : {{(AW-PW){1'b0}}, bus.r};
        s2 = bus.killprod ? '0 : {{(AW-PW){1'b0}}, bus.s};
        t2 = bus.invz ? ~bus.t : bus.t;
    end

    fma_csa32 #(.W(AW)) u_csa (
        .a     (r2),
        .b     (s2),
        .c     (t2),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    always_comb begin
        v1_d    = v1_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        invz1_d = invz1_q;
        tag1_d  = tag1_q;
        if (adv1) begin
            v1_d    = bus.in_valid;
            sum_d   = csa_sum;
            carry_d = csa_carry;
            invz1_d = bus.invz;
            tag1_d  = bus.tag_in;
        end
        if (bus.flush) begin
            v1_d = 1'b0;
        end
    end

    // For a subtract, sum0 = P - t - 1 and sum1 = P - t. If sum1 is negative
    // then ~sum0 = t - P is the magnitude.
    always_comb begin
        sum0 = sum_q + carry_q;
        sum1 = sum0 + {{(AW-1){1'b0}}, 1'b1};
        if (!invz1_q) begin
            sel_mode = ADD0;
        end else if (!sum1[AW-1]) begin
            sel_mode = ADD1;
        end else begin
            sel_mode = INV0;
        end
        unique case (sel_mode)
            ADD0:    begin sel_mag = sum0;  sel_neg = 1'b0; end
            ADD1:    begin sel_mag = sum1;  sel_neg = 1'b0; end
            INV0:    begin sel_mag = ~sum0; sel_neg = 1'b1; end
            default: begin sel_mag = sum0;  sel_neg = 1'b0; end
        endcase
    end

    always_comb begin
        v2_d     = v2_q;
        mag_d    = mag_q;
        negsum_d = negsum_q;
        zero_d   = zero_q;
        tag2_d   = tag2_q;
        if (adv2) begin
            v2_d     = v1_q;
            mag_d    = sel_mag;
            zero_d   = (sel_mag == '0);
            // A zero result is never reported as negative.
            negsum_d = sel_neg && (sel_mag != '0);
            tag2_d   = tag1_q;
        end
        if (bus.flush) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q     <= 1'b0;
            sum_q    <= '0;
            carry_q  <= '0;
            invz1_q  <= 1'b0;
            tag1_q   <= '0;
            v2_q     <= 1'b0;
            mag_q    <= '0;
            negsum_q <= 1'b0;
            zero_q   <= 1'b0;
            tag2_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            invz1_q  <= invz1_d;
            tag1_q   <= tag1_d;
            v2_q     <= v2_d;
            mag_q    <= mag_d;
            negsum_q <= negsum_d;
            zero_q   <= zero_d;
            tag2_q   <= tag2_d;
        end
    end

    always_comb begin
        bus.in_ready  = adv1;
        bus.out_valid = v2_q;
        bus.mag       = mag_q;
        bus.negsum    = negsum_q;
        bus.zero      = zero_q;
        bus.tag_out   = tag2_q;
    end
endmodule
